imem_pipe: RTL and testbench



---
 rtl/imem_pipe.sv | 99 +++++++++
 tb/tb_imem_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_pipe.sv
// Pipelined instruction memory: valid/ready fetch port, LATENCY-stage read pipe, flush, preload port.
// Optional address-fault detection is enabled by defining IMEM_FAULT_CHECK_EN.
module imem_pipe #(
    parameter int          DEPTH_LOG2 = 3,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_pc,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_inst,
    output logic [31:0]           rsp_pc,
    output logic                  rsp_fault,
    input  logic                  flush,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);
    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]         mem [DEPTH];

    logic [LATENCY-1:0]  vld_p;
    logic [LATENCY-1:0]  fault_p;
    logic [31:0]         pc_p   [LATENCY];
    logic [31:0]         inst_p [LATENCY];

    logic                adv;
    logic                accept;
    logic [31:0]         offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic                req_fault;
    logic                unused_offset_bits;

    assign adv       = !rsp_valid || rsp_ready;
    assign req_ready = adv && !flush && !rst;
    assign accept    = req_valid && req_ready;

    assign offset = req_pc - BASE_ADDR;
    assign idx    = offset[DEPTH_LOG2+1:2];
    assign unused_offset_bits = ^{offset[31:DEPTH_LOG2+2], offset[1:0]};

`ifdef IMEM_FAULT_CHECK_EN
    // A PC below BASE_ADDR wraps the offset to a huge value, so it lands in the range fault too.
    assign req_fault = (req_pc[1:0] != 2'b00) || ((offset >> (DEPTH_LOG2 + 2)) != 32'd0);
`else
    assign req_fault = 1'b0;
`endif

    // Load port: independent of handshake/flush; the fetch read below sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Stage valids: flush and reset drop everything in flight, otherwise shift on global advance.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p <= '0;
        end else if (adv) begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Stage data: not reset; the outputs are masked by the last-stage valid instead.
    always_ff @(posedge clk) begin
        if (adv) begin
            if (accept) begin
                pc_p[0]    <= req_pc;
                fault_p[0] <= req_fault;
                if (req_fault) begin
                    inst_p[0] <= NOP;
                end else begin
                    inst_p[0] <= mem[idx];
                end
            end
            for (int i = 1; i < LATENCY; i++) begin
                pc_p[i]    <= pc_p[i-1];
                inst_p[i]  <= inst_p[i-1];
                fault_p[i] <= fault_p[i-1];
            end
        end
    end

    assign rsp_valid = vld_p[LATENCY-1];
    assign rsp_inst  = rsp_valid ? inst_p[LATENCY-1] : 32'd0;
    assign rsp_pc    = rsp_valid ? pc_p[LATENCY-1]   : 32'd0;
    assign rsp_fault = rsp_valid && fault_p[LATENCY-1];

endmodule

// File: tb/tb_imem_pipe.sv
// Directed bench for imem_pipe: three instances with LATENCY 1, 3 and 2 sharing clock, reset and load port.
module tb_imem_pipe;
`ifdef IMEM_FAULT_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [2:0]  load_addr;
    logic [31:0] load_data;

    logic [2:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, flush;
    logic [31:0] req_pc   [3];
    logic [31:0] rsp_inst [3];
    logic [31:0] rsp_pc   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_pipe #(.DEPTH_LOG2(3), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_pc(req_pc[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_inst(rsp_inst[0]), .rsp_pc(rsp_pc[0]), .rsp_fault(rsp_fault[0]),
        .flush(flush[0]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    imem_pipe #(.DEPTH_LOG2(3), .LATENCY(3), .BASE_ADDR(32'h0)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_pc(req_pc[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_inst(rsp_inst[1]), .rsp_pc(rsp_pc[1]), .rsp_fault(rsp_fault[1]),
        .flush(flush[1]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    imem_pipe #(.DEPTH_LOG2(3), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_pc(req_pc[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_inst(rsp_inst[2]), .rsp_pc(rsp_pc[2]), .rsp_fault(rsp_fault[2]),
        .flush(flush[2]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words [8];

    initial begin
        words = '{32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc, 32'hdddddddd,
                  32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        req_valid = '0; rsp_ready = '0; flush = '0;
        for (int d = 0; d < 3; d++) req_pc[d] = '0;

        // Reset state
        tick(); tick();
        check("rst_req_ready", {29'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {29'd0, rsp_valid}, 32'd0);
        check("rst_rsp_inst",  rsp_inst[0], 32'd0);
        check("rst_rsp_pc",    rsp_pc[1],   32'd0);
        rst = 1'b0;

        // Preload all eight words
        for (int i = 0; i < 8; i++) begin
            load_en = 1'b1; load_addr = 3'(i); load_data = words[i];
            tick();
        end
        load_en = 1'b0;

        // LATENCY=1 back-to-back fetch
        rsp_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid[0] = 1'b1; req_pc[0] = 32'(4 * k);
            #1 check("l1_req_ready", {31'd0, req_ready[0]}, 32'd1);
            tick();
            check("l1_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            check("l1_rsp_inst",  rsp_inst[0], words[k]);
            check("l1_rsp_pc",    rsp_pc[0], 32'(4 * k));
        end
        req_valid[0] = 1'b0;
        tick();
        check("l1_idle_valid", {31'd0, rsp_valid[0]}, 32'd0);

        // LATENCY=3 with back-pressure
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1; req_pc[1] = 32'h4;
        tick();
        req_valid[1] = 1'b0;
        check("l3_e1_valid", {31'd0, rsp_valid[1]}, 32'd0);
        tick();
        check("l3_e2_valid", {31'd0, rsp_valid[1]}, 32'd0);
        tick();
        check("l3_e3_valid", {31'd0, rsp_valid[1]}, 32'd1);
        check("l3_e3_inst",  rsp_inst[1], 32'hbbbbbbbb);
        req_valid[1] = 1'b1; req_pc[1] = 32'h8;
        for (int c = 0; c < 5; c++) begin
            check("l3_hold_ready", {31'd0, req_ready[1]}, 32'd0);
            tick();
            check("l3_hold_valid", {31'd0, rsp_valid[1]}, 32'd1);
            check("l3_hold_inst",  rsp_inst[1], 32'hbbbbbbbb);
            check("l3_hold_pc",    rsp_pc[1], 32'h4);
        end
        rsp_ready[1] = 1'b1;
        #1 check("l3_release_ready", {31'd0, req_ready[1]}, 32'd1);
        tick();
        req_valid[1] = 1'b0;
        check("l3_a_valid", {31'd0, rsp_valid[1]}, 32'd0);
        tick();
        check("l3_b_valid", {31'd0, rsp_valid[1]}, 32'd0);
        tick();
        check("l3_c_valid", {31'd0, rsp_valid[1]}, 32'd1);
        check("l3_c_inst",  rsp_inst[1], 32'hcccccccc);
        check("l3_c_pc",    rsp_pc[1], 32'h8);
        tick();
        check("l3_d_valid", {31'd0, rsp_valid[1]}, 32'd0);

        // LATENCY=2 flush with two requests in flight
        rsp_ready[2] = 1'b0;
        req_valid[2] = 1'b1; req_pc[2] = 32'h0;
        tick();
        req_pc[2] = 32'h4;
        tick();
        req_pc[2] = 32'h8;
        flush[2] = 1'b1;
        #1 check("fl_req_ready", {31'd0, req_ready[2]}, 32'd0);
        tick();
        flush[2] = 1'b0; req_valid[2] = 1'b0; rsp_ready[2] = 1'b1;
        check("fl_valid_0", {31'd0, rsp_valid[2]}, 32'd0);
        tick();
        check("fl_valid_1", {31'd0, rsp_valid[2]}, 32'd0);
        req_valid[2] = 1'b1; req_pc[2] = 32'hC;
        tick();
        req_valid[2] = 1'b0;
        check("fl_next_lat", {31'd0, rsp_valid[2]}, 32'd0);
        tick();
        check("fl_next_valid", {31'd0, rsp_valid[2]}, 32'd1);
        check("fl_next_inst",  rsp_inst[2], 32'hdddddddd);
        check("fl_next_pc",    rsp_pc[2], 32'hC);

        // Same-edge load and fetch of index 1 (LATENCY=1)
        load_en = 1'b1; load_addr = 3'd1; load_data = 32'h12345678;
        req_valid[0] = 1'b1; req_pc[0] = 32'h4;
        tick();
        load_en = 1'b0;
        check("col_old_inst", rsp_inst[0], 32'hbbbbbbbb);
        tick();
        check("col_new_inst", rsp_inst[0], 32'h12345678);

        // Address faults (or silent wrap when checking is compiled out)
        req_pc[0] = 32'h2;
        tick();
        check("flt_mis_fault", {31'd0, rsp_fault[0]}, FC ? 32'd1 : 32'd0);
        check("flt_mis_inst",  rsp_inst[0], FC ? 32'h00000013 : 32'haaaaaaaa);
        req_pc[0] = 32'h20;
        tick();
        check("flt_oob_fault", {31'd0, rsp_fault[0]}, FC ? 32'd1 : 32'd0);
        check("flt_oob_inst",  rsp_inst[0], FC ? 32'h00000013 : 32'haaaaaaaa);
        check("flt_oob_pc",    rsp_pc[0], 32'h20);
        req_pc[0] = 32'h1C;
        tick();
        check("flt_top_fault", {31'd0, rsp_fault[0]}, 32'd0);
        check("flt_top_inst",  rsp_inst[0], 32'h77777777);
        req_valid[0] = 1'b0;
        tick();

        // Reset with requests in flight (LATENCY=3)
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_pc[1] = 32'h0;
        tick();
        req_pc[1] = 32'h4;
        tick();
        req_valid[1] = 1'b0;
        rst = 1'b1;
        #1 check("mr_req_ready", {31'd0, req_ready[1]}, 32'd0);
        tick();
        check("mr_valid", {31'd0, rsp_valid[1]}, 32'd0);
        check("mr_inst",  rsp_inst[1], 32'd0);
        check("mr_pc",    rsp_pc[1], 32'd0);
        check("mr_fault", {31'd0, rsp_fault[1]}, 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mr_drop_valid", {31'd0, rsp_valid[1]}, 32'd0);
        end

        // Contents survive reset
        req_valid[0] = 1'b1; req_pc[0] = 32'h0;
        tick();
        check("keep_w0", rsp_inst[0], 32'haaaaaaaa);
        req_pc[0] = 32'h8;
        tick();
        check("keep_w2", rsp_inst[0], 32'hcccccccc);
        req_valid[0] = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
